// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared types and default widths for the sequential divider
// Purpose: FSM state encoding and default operand widths used by seq_div and seq_div_if.
// Ports: none (package).
package seq_div_pkg;

  localparam int DVD_W_DEF = 10;
  localparam int DVS_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_div_if.sv
// rtl/seq_div_if.sv - request/result bundle between a divider client and seq_div
// Purpose: groups the start handshake, operands and held results.
// Ports: master drives start/dividend/divisor and observes busy/done/quot/rem/div0/ovf;
//        slave (the divider) is the mirror image.
interface seq_div_if
  import seq_div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) ();

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DVD_W-1:0] quot;
  logic [DVS_W-1:0] rem;
  logic             div0;
  logic             ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quot, rem, div0, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quot, rem, div0, ovf
  );

endinterface

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one restoring shift/trial-subtract step on unsigned magnitudes
// Purpose: shifts the next dividend bit into the partial remainder and subtracts the
//          divisor when it fits.
// Ports: rem_in (partial remainder), bit_in (next dividend bit), divisor (magnitude),
//        rem_out (new partial remainder), q_bit (quotient bit for this step).
module seq_div_step #(
  parameter int DVS_W = 5
) (
  input  logic [DVS_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] rem_out,
  output logic             q_bit
);

  logic [DVS_W:0] shifted;
  logic [DVS_W:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    // shifted < 2*divisor always holds, so the top bit of diff is a clean borrow flag.
    q_bit   = ~diff[DVS_W];
    rem_out = q_bit ? diff[DVS_W-1:0] : shifted[DVS_W-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle restoring divider with divide-by-zero and overflow flags
// Purpose: IDLE -> RUN (DVD_W steps) -> CORR (sign fix) -> DONE; zero divisor jumps to DONE.
// Ports: clk, rst (synchronous, active-high), bus (seq_div_if.slave: start/operands in,
//        busy/done/quot/rem/div0/ovf out).
// Config: define SEQ_DIV_SIGNED_EN for two's-complement operands; default is unsigned.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  seq_div_if.slave bus
);

  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

  state_t           state_q, state_d;
  // acc shifts dividend bits out at the top while quotient bits enter at the bottom.
  logic [DVD_W-1:0] acc_q, acc_d;
  logic [DVS_W-1:0] prem_q, prem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVD_W-1:0] quot_q, quot_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;

  logic [DVD_W-1:0] dvd_mag;
  logic [DVS_W-1:0] dvs_mag;
  logic [DVD_W-1:0] quot_fix;
  logic [DVS_W-1:0] rem_fix;
  logic             ovf_fix;
  logic [DVS_W-1:0] step_rem;
  logic             step_bit;

`ifdef SEQ_DIV_SIGNED_EN
  logic dvd_neg_q, dvd_neg_d;
  logic dvs_neg_q, dvs_neg_d;
  logic q_neg;

  always_comb begin
    dvd_mag  = bus.dividend[DVD_W-1] ? -bus.dividend : bus.dividend;
    dvs_mag  = bus.divisor[DVS_W-1]  ? -bus.divisor  : bus.divisor;
    q_neg    = dvd_neg_q ^ dvs_neg_q;
    quot_fix = q_neg ? -acc_q : acc_q;
    rem_fix  = dvd_neg_q ? -prem_q : prem_q;
    // Only most-negative / -1 yields a positive magnitude with the sign bit set.
    ovf_fix  = ~q_neg & acc_q[DVD_W-1];
  end
`else
  always_comb begin
    dvd_mag  = bus.dividend;
    dvs_mag  = bus.divisor;
    quot_fix = acc_q;
    rem_fix  = prem_q;
    ovf_fix  = 1'b0;
  end
`endif

  seq_div_step #(.DVS_W(DVS_W)) u_step (
    .rem_in  (prem_q),
    .bit_in  (acc_q[DVD_W-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
`ifdef SEQ_DIV_SIGNED_EN
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d  = dvd_mag;
          dvs_d  = dvs_mag;
          prem_d = '0;
          cnt_d  = '0;
          div0_d = 1'b0;
          ovf_d  = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
          dvd_neg_d = bus.dividend[DVD_W-1];
          dvs_neg_d = bus.divisor[DVS_W-1];
`endif
          if (bus.divisor == '0) begin
            quot_d  = '1;
            rem_d   = '0;
            div0_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d  = {acc_q[DVD_W-2:0], step_bit};
        prem_d = step_rem;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = CORR;
        end
      end
      CORR: begin
        quot_d  = quot_fix;
        rem_d   = rem_fix;
        ovf_d   = ovf_fix;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
`ifdef SEQ_DIV_SIGNED_EN
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.div0 = div0_q;
  assign bus.ovf  = ovf_q;

endmodule
